obc_bitserial_acc: RTL
======================

Name: obc_bitserial_acc

Overview:
- Bit-serial sequencer and shift-accumulator for the OBC distributed-arithmetic DFT datapath.
- Captures one block of 16 samples and presents one bit-slice per cycle, MSB first, to the combinational OBC ROM stage.
- Asserts the sign-select flag during the MSB slice.
- Accumulates the returned partial sum with a shift and the ROM offset term, and emits one DFT output word per block over a valid/ready handshake.

Parameters:
- DATA_W, 16: sample width in bits; number of bit-slice cycles per block (legal range 2..31).
- ACC_W, 32: ROM partial-sum width and accumulator/result width.
- RND_SH, 8: result right-shift amount. Used only with OBC_ROUND_EN; 0 < RND_SH < ACC_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample block offered.
- in_ready  out  1  block accepted when in_valid && in_ready.
- x_in  in  16*DATA_W  16 packed samples; sample n at bits [n*DATA_W +: DATA_W].
- rom_ofs  in  ACC_W  OBC offset term; sampled together with x_in.
- slice_out  out  16  current bit-slice; bit n = bit (DATA_W-1-k) of sample n at step k.
- sign_out  out  1  sign-select to ROM stage; 1 only at step k=0 (MSB slice).
- romout  in  ACC_W  combinational ROM-stage sum for the current slice_out/sign_out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- dft_out  out  ACC_W  result word.

Behaviour:
- Reset values (rst=1 at an edge): state IDLE, in_ready=1, out_valid=0, slice_out=0, sign_out=0, dft_out=0, step counter=0, accumulator=0.
- States: IDLE, SHIFT, OFS, HOLD.
- IDLE
  - in_ready=1.
  - On handshake: latch x_in into the sample register and rom_ofs into the offset register; clear acc; k=0; go to SHIFT.
- SHIFT
  - in_ready=0.
  - slice_out and sign_out are driven from registers and are valid for the whole cycle of step k.
  - Each cycle: acc <= (acc << 1) + romout, modulo 2^ACC_W, two's complement; romout is sampled in the same cycle as its slice.
  - k increments each cycle. After step k=DATA_W-1, go to OFS.
- OFS
  - acc <= acc + offset register.
  - slice_out=0, sign_out=0. Go to HOLD.
- HOLD
  - out_valid=1; dft_out=acc (or the rounded value with OBC_ROUND_EN); dft_out stays stable while out_valid && !out_ready.
  - On out_ready: out_valid falls next cycle.
  - If in_valid is also high in the handshake cycle: in_ready=1 in HOLD, the new block is captured, and the state goes straight to SHIFT (zero-bubble back-to-back).
  - Otherwise go to IDLE.
- Result: dft_out = sum_{k=0..DATA_W-1} romout_k * 2^(DATA_W-1-k) + rom_ofs, mod 2^ACC_W.
- Latency: handshake at cycle t; slices at t+1..t+DATA_W; OFS at t+DATA_W+1; out_valid at t+DATA_W+2.
- Throughput: one block per DATA_W+2 cycles with out_ready held high.
- in_valid while busy (SHIFT/OFS, or HOLD without out_ready) is ignored; in_ready=0, no capture.
- rst in any state aborts the block immediately. No partial result is emitted, and the first post-reset handshake behaves as from power-up.
- Arithmetic overflow wraps silently; there is no status flag.

Optional Feature:
- Macro: OBC_ROUND_EN.
- Defined: dft_out = (acc + 2^(RND_SH-1)) >>> RND_SH, arithmetic shift with round-half-up. The rounding add is done in ACC_W+1 bits and the result is sign-extended back to ACC_W. The rounding happens combinationally from the accumulator, so latency is unchanged.
- Undefined: dft_out = acc, unscaled; RND_SH is unused.

Test Plan:
1. Reset then a block with romout forced to 1 every SHIFT cycle and rom_ofs=0 -> dft_out=0x0000FFFF at t+18. out_valid first high at t+18; sign_out high only at t+1.
2. Sample 0 = 0x8001, all other samples 0 -> slice_out=0x0001 at t+1 and t+16, 0x0000 at t+2..t+15. Bench ROM model returns (slice_out[0] ? (sign_out ? -5 : 5) : 0) and rom_ofs=3 -> dft_out = -5*32768 + 5 + 3 = 0xFFFD8008.
3. Back-to-back: in_valid held high with two blocks, out_ready=1 -> second result 18 cycles after the first, and in_ready is never asserted during SHIFT/OFS.
4. Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid and dft_out stable. A new in_valid is not accepted until out_ready=1.
5. Reset mid-operation: rst asserted at step k=7 -> next cycle state IDLE, out_valid=0, slice_out=0. A following block with romout=1 gives 0x0000FFFF again.
6. With OBC_ROUND_EN and RND_SH=8: acc=0x00000180 -> dft_out=0x00000002; acc=0xFFFFFE80 -> dft_out=0xFFFFFFFF. Without the macro, dft_out=acc.

Source files
------------

// File: rtl/obc_bitserial_acc.sv
// rtl/obc_bitserial_acc.sv - OBC bit-serial slice sequencer and shift-accumulator.
// Define OBC_ROUND_EN to round and scale dft_out by RND_SH bits (round-half-up).
module obc_bitserial_acc #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int RND_SH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*DATA_W-1:0]  x_in,
    input  logic [ACC_W-1:0]      rom_ofs,
    output logic [15:0]           slice_out,
    output logic                  sign_out,
    input  logic [ACC_W-1:0]      romout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      dft_out
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_OFS   = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;
    localparam logic [4:0] K_LAST  = 5'(DATA_W - 1);

    if (DATA_W < 2 || DATA_W > 31 || RND_SH < 1 || RND_SH >= ACC_W) begin : g_bad_params
        $error("obc_bitserial_acc: DATA_W or RND_SH out of range");
    end

    logic [1:0]        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  ofs_q, ofs_d;
    logic [4:0]        k_q, k_d;
    logic [15:0]       slice_q, slice_d;
    logic              sign_q, sign_d;
    // MSBs leave straight into slice_q at capture, so only the lower bits are kept
    logic [DATA_W-2:0] smp_q [16];
    logic [DATA_W-2:0] smp_d [16];
    logic              take;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign take      = in_valid && in_ready;
    assign out_valid = (state_q == S_HOLD);
    assign slice_out = slice_q;
    assign sign_out  = sign_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ofs_d   = ofs_q;
        k_d     = k_q;
        slice_d = slice_q;
        sign_d  = sign_q;
        for (int n = 0; n < 16; n++) smp_d[n] = smp_q[n];

        case (state_q)
            S_SHIFT: begin
                acc_d  = (acc_q << 1) + romout;
                k_d    = k_q + 5'd1;
                sign_d = 1'b0;
                for (int n = 0; n < 16; n++) begin
                    slice_d[n] = smp_q[n][DATA_W-2];
                    smp_d[n]   = smp_q[n] << 1;
                end
                if (k_q == K_LAST) begin
                    state_d = S_OFS;
                    slice_d = '0;
                    k_d     = '0;
                end
            end
            S_OFS: begin
                acc_d   = acc_q + ofs_q;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        // Capture overrides HOLD so a waiting block starts with no bubble
        if (take) begin
            state_d = S_SHIFT;
            acc_d   = '0;
            ofs_d   = rom_ofs;
            k_d     = '0;
            sign_d  = 1'b1;
            for (int n = 0; n < 16; n++) begin
                slice_d[n] = x_in[n*DATA_W + DATA_W - 1];
                smp_d[n]   = x_in[n*DATA_W +: DATA_W-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ofs_q   <= '0;
            k_q     <= '0;
            slice_q <= '0;
            sign_q  <= 1'b0;
            for (int n = 0; n < 16; n++) smp_q[n] <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ofs_q   <= ofs_d;
            k_q     <= k_d;
            slice_q <= slice_d;
            sign_q  <= sign_d;
            for (int n = 0; n < 16; n++) smp_q[n] <= smp_d[n];
        end
    end

`ifdef OBC_ROUND_EN
    localparam logic [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (RND_SH - 1);
    logic signed [ACC_W:0] rnd_sum;
    // One extra bit keeps the half-LSB add from overflowing before the shift
    assign rnd_sum = $signed({acc_q[ACC_W-1], acc_q}) + $signed(RND_HALF);
    assign dft_out = ACC_W'(rnd_sum >>> RND_SH);
`else
    assign dft_out = acc_q;
`endif
endmodule
